// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller: syscall FSM
// state encoding, forwarding select codes and the hardwired-zero register.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FIRE  = 2'd2
    } sys_state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $0 is hardwired to zero, so a dependency on it is never real.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != REG_ZERO) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of pipeline-side signals seen by the hazard controller.
// Handshake: there is no valid/ready pair; every signal is level-sensitive
// and sampled each cycle. The pipeline (master) drives stage specifiers and
// control bits; the controller (slave) returns stall, flush, forward selects
// and the one-cycle syscall_go pulse, all combinational within the cycle.
interface hazard_ctrl_if;

    logic [4:0] rsD;
    logic [4:0] rtD;
    logic [4:0] rsE;
    logic [4:0] rtE;
    logic [4:0] writeregE;
    logic [4:0] writeregM;
    logic [4:0] writeregW;
    logic       regwriteE;
    logic       regwriteM;
    logic       regwriteW;
    logic       memtoregE;
    logic       memtoregM;
    logic       branchD;
    logic       jrD;
    logic       syscallD;

    logic       stallF;
    logic       stallD;
    logic       flushE;
    logic       forwardAD;
    logic       forwardBD;
    logic [1:0] forwardAE;
    logic [1:0] forwardBE;
    logic       syscall_go;

    modport master (
        output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, syscallD,
        input  stallF, stallD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, syscall_go
    );

    modport slave (
        input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoregE, memtoregM,
               branchD, jrD, syscallD,
        output stallF, stallD, flushE, forwardAD, forwardBD,
               forwardAE, forwardBE, syscall_go
    );

endinterface

// File: rtl/hazard_syscall_fsm.sv
// Syscall sequencer: a syscall held in decode (with no hazard pending)
// drains E/M/W for DRAIN_CYCLES cycles, then pulses syscall_go for one
// cycle and returns to RUN unconditionally. State is exposed for debug.
module hazard_syscall_fsm
    import mips_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       syscallD,
    input  logic       hz,
    output logic [1:0] state,
    output logic [2:0] cnt,
    output logic       syscall_go
);

    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;
    localparam logic [1:0] ST_FIRE  = FIRE;

    localparam logic [2:0] CNT_LOAD = 3'(DRAIN_CYCLES - 1);

    // State and drain counter; a hazard always wins over starting a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (syscallD && !hz) begin
                        state <= ST_DRAIN;
                        cnt   <= CNT_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (cnt == 3'd0) begin
                        state <= ST_FIRE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_FIRE: begin
                    state <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign syscall_go = (state == ST_FIRE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage MIPS core: forwarding
// selects, load-use / branch / jr stalls, execute flush, and syscall drain
// sequencing. Optional feature macro: HAZARD_PERF_EN adds the stall_cycles
// counter port (saturating count of cycles with stallD high).
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_ctrl_if.slave hif
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic       lwstall;
    logic       brstall;
    logic       jrstall;
    logic       hz;
    logic       stall;
    logic [1:0] state;
    logic [2:0] cnt;

    // Execute-stage forwarding: M result has priority over W result.
    always_comb begin
        hif.forwardAE = FWD_RF;
        if (hif.regwriteM && reg_match(hif.rsE, hif.writeregM)) begin
            hif.forwardAE = FWD_MEM;
        end else if (hif.regwriteW && reg_match(hif.rsE, hif.writeregW)) begin
            hif.forwardAE = FWD_WB;
        end
        hif.forwardBE = FWD_RF;
        if (hif.regwriteM && reg_match(hif.rtE, hif.writeregM)) begin
            hif.forwardBE = FWD_MEM;
        end else if (hif.regwriteW && reg_match(hif.rtE, hif.writeregW)) begin
            hif.forwardBE = FWD_WB;
        end
    end

    // Decode comparator / JR address forwarding from the M-stage ALU result.
    always_comb begin
        hif.forwardAD = hif.regwriteM && reg_match(hif.rsD, hif.writeregM);
        hif.forwardBD = hif.regwriteM && reg_match(hif.rtD, hif.writeregM);
    end

    // Hazard detection: load-use, plus branch/jr needing a value not yet
    // available (ALU result still in E, or load data still in M).
    always_comb begin
        lwstall = hif.memtoregE && hif.regwriteE &&
                  (reg_match(hif.rsD, hif.writeregE) || reg_match(hif.rtD, hif.writeregE));
        brstall = hif.branchD &&
                  ((hif.regwriteE &&
                    (reg_match(hif.rsD, hif.writeregE) || reg_match(hif.rtD, hif.writeregE))) ||
                   (hif.memtoregM &&
                    (reg_match(hif.rsD, hif.writeregM) || reg_match(hif.rtD, hif.writeregM))));
        jrstall = hif.jrD &&
                  ((hif.regwriteE && reg_match(hif.rsD, hif.writeregE)) ||
                   (hif.memtoregM && reg_match(hif.rsD, hif.writeregM)));
        hz      = lwstall || brstall || jrstall;
    end

    hazard_syscall_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_syscall_fsm (
        .clk        (clk),
        .rst_n      (rst_n),
        .syscallD   (hif.syscallD),
        .hz         (hz),
        .state      (state),
        .cnt        (cnt),
        .syscall_go (hif.syscall_go)
    );

    // Stall source depends on FSM state; everything is forced low in reset.
    always_comb begin
        case (state)
            2'(RUN):   stall = hz;
            2'(DRAIN): stall = 1'b1;
            default:   stall = 1'b0;
        endcase
        stall      = stall && rst_n;
        hif.stallF = stall;
        hif.stallD = stall;
        hif.flushE = stall;
    end

`ifdef HAZARD_PERF_EN
    // Saturating count of cycles in which decode was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= 32'd0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // cnt is observed only through the FSM's state transitions here.
    logic unused_cnt;
    assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, stalls, $0 immunity,
// syscall drain/fire timing, hazard-vs-syscall priority, back-to-back
// syscalls, reset mid-drain and (with HAZARD_PERF_EN) the stall counter.
module tb_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    hazard_ctrl_if hif();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
`endif

    hazard_ctrl #(
        .DRAIN_CYCLES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle();
        hif.rsD = 5'd0; hif.rtD = 5'd0; hif.rsE = 5'd0; hif.rtE = 5'd0;
        hif.writeregE = 5'd0; hif.writeregM = 5'd0; hif.writeregW = 5'd0;
        hif.regwriteE = 1'b0; hif.regwriteM = 1'b0; hif.regwriteW = 1'b0;
        hif.memtoregE = 1'b0; hif.memtoregM = 1'b0;
        hif.branchD = 1'b0; hif.jrD = 1'b0; hif.syscallD = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {stallF, stallD, flushE, syscall_go}
    function automatic logic [3:0] ctl();
        return {hif.stallF, hif.stallD, hif.flushE, hif.syscall_go};
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        idle();
        rst_n = 1'b0;
        // hazard and forwarding inputs active while held in reset
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd8; hif.rsD = 5'd8;
        hif.rsE = 5'd8; hif.writeregM = 5'd8; hif.regwriteM = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", obs, 4'b0000);
        end
        n_cmp++;
        if (hif.forwardAE !== 2'b10) begin
            n_err++; $display("FAIL reset_fwdAE: got %b want %b", hif.forwardAE, 2'b10);
        end
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctl_edge: got %b want %b", obs, 4'b0000);
        end
`ifdef HAZARD_PERF_EN
        n_cmp++;
        if (stall_cycles !== 32'd0) begin
            n_err++; $display("FAIL reset_perf: got %0d want 0", stall_cycles);
        end
`endif
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        logic [3:0] obs;
        idle();
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd8; hif.rsD = 5'd8;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL lw_stall_rs: got %b want %b", obs, 4'b1110);
        end
        hif.rsD = 5'd3; hif.rtD = 5'd8;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL lw_stall_rt: got %b want %b", obs, 4'b1110);
        end
        tick();
        // load now in M, dependent instruction in E
        idle();
        hif.writeregM = 5'd8; hif.regwriteM = 1'b1; hif.memtoregM = 1'b1; hif.rsE = 5'd8;
        hif.rtE = 5'd5; hif.writeregW = 5'd5; hif.regwriteW = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL lw_clear: got %b want %b", obs, 4'b0000);
        end
        n_cmp++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b1001) begin
            n_err++; $display("FAIL lw_fwdE: got %b want %b", {hif.forwardAE, hif.forwardBE}, 4'b1001);
        end
        // M has priority over W for the same register
        hif.writeregW = 5'd8;
        hif.rtE = 5'd8;
        #1;
        n_cmp++;
        if ({hif.forwardAE, hif.forwardBE} !== 4'b1010) begin
            n_err++; $display("FAIL fwd_prio: got %b want %b", {hif.forwardAE, hif.forwardBE}, 4'b1010);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [3:0] obs;
        idle();
        hif.branchD = 1'b1; hif.rsD = 5'd4; hif.rtD = 5'd9;
        hif.regwriteE = 1'b1; hif.writeregE = 5'd9;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL br_stall: got %b want %b", obs, 4'b1110);
        end
        tick();
        hif.regwriteE = 1'b0; hif.writeregE = 5'd0;
        hif.writeregM = 5'd9; hif.regwriteM = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000 || hif.forwardBD !== 1'b1 || hif.forwardAD !== 1'b0) begin
            n_err++; $display("FAIL br_fwd: got ctl=%b AD=%b BD=%b want ctl=0000 AD=0 BD=1",
                              obs, hif.forwardAD, hif.forwardBD);
        end
        // load result still in M: branch must wait
        hif.memtoregM = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL br_load_m: got %b want %b", obs, 4'b1110);
        end
        // jr reads rs only: an rt match does not stall
        idle();
        hif.jrD = 1'b1; hif.rsD = 5'd7; hif.rtD = 5'd9;
        hif.regwriteE = 1'b1; hif.writeregE = 5'd9;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL jr_rt_nostall: got %b want %b", obs, 4'b0000);
        end
        hif.writeregE = 5'd7;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL jr_rs_stall: got %b want %b", obs, 4'b1110);
        end
        hif.regwriteE = 1'b0; hif.writeregM = 5'd7; hif.regwriteM = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000 || hif.forwardAD !== 1'b1) begin
            n_err++; $display("FAIL jr_fwd: got ctl=%b AD=%b want ctl=0000 AD=1", obs, hif.forwardAD);
        end
        idle();
        tick();
    endtask

    task automatic test_zero_reg();
        logic [3:0] obs;
        idle();
        hif.writeregM = 5'd0; hif.regwriteM = 1'b1; hif.rsE = 5'd0; hif.rsD = 5'd0;
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd0;
        hif.rtE = 5'd0; hif.writeregW = 5'd0; hif.regwriteW = 1'b1;
        hif.branchD = 1'b1; hif.memtoregM = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL zero_stall: got %b want %b", obs, 4'b0000);
        end
        n_cmp++;
        if ({hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD} !== 6'b000000) begin
            n_err++; $display("FAIL zero_fwd: got %b want %b",
                              {hif.forwardAE, hif.forwardBE, hif.forwardAD, hif.forwardBD}, 6'b000000);
        end
        idle();
        tick();
    endtask

    task automatic test_syscall();
        logic [3:0] obs;
        idle();
        hif.syscallD = 1'b1;  // cycle T
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL sys_T: got %b want %b", obs, 4'b0000);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = ctl();
            n_cmp++;
            if (obs !== 4'b1110) begin
                n_err++; $display("FAIL sys_drain%0d: got %b want %b", i, obs, 4'b1110);
            end
        end
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0001) begin
            n_err++; $display("FAIL sys_fire: got %b want %b", obs, 4'b0001);
        end
        hif.syscallD = 1'b0;
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL sys_run: got %b want %b", obs, 4'b0000);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        logic [3:0] exp_seq [0:9];
        idle();
        // T, D, D, D, FIRE, RUN(second seen), D, D, D, FIRE
        exp_seq = '{4'b0000, 4'b1110, 4'b1110, 4'b1110, 4'b0001,
                    4'b0000, 4'b1110, 4'b1110, 4'b1110, 4'b0001};
        hif.syscallD = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) begin
            obs = ctl();
            n_cmp++;
            if (obs !== exp_seq[i]) begin
                n_err++; $display("FAIL b2b_cyc%0d: got %b want %b", i, obs, exp_seq[i]);
            end
            tick();
        end
        idle();
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL b2b_end: got %b want %b", obs, 4'b0000);
        end
        tick();
    endtask

    task automatic test_syscall_hz();
        logic [3:0] obs;
        idle();
        hif.syscallD = 1'b1;
        hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd6; hif.rtD = 5'd6;
        for (int i = 0; i < 2; i++) begin
            #1;
            obs = ctl();
            n_cmp++;
            if (obs !== 4'b1110) begin
                n_err++; $display("FAIL syshz_stall%0d: got %b want %b", i, obs, 4'b1110);
            end
            tick();
        end
        // hazard clears: still RUN this cycle, drain starts next
        hif.memtoregE = 1'b0; hif.regwriteE = 1'b0; hif.writeregE = 5'd0;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL syshz_run: got %b want %b", obs, 4'b0000);
        end
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL syshz_drain: got %b want %b", obs, 4'b1110);
        end
        tick();
        tick();
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0001) begin
            n_err++; $display("FAIL syshz_fire: got %b want %b", obs, 4'b0001);
        end
        idle();
        tick();
    endtask

    task automatic test_reset_mid_drain();
        logic [3:0] obs;
        idle();
        hif.syscallD = 1'b1;  // cycle 10
        tick();               // 11
        tick();               // 12
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b1110) begin
            n_err++; $display("FAIL rmd_pre: got %b want %b", obs, 4'b1110);
        end
        rst_n = 1'b0;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL rmd_async: got %b want %b", obs, 4'b0000);
        end
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL rmd_hold: got %b want %b", obs, 4'b0000);
        end
        rst_n = 1'b1;
        #1;
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0000) begin
            n_err++; $display("FAIL rmd_release: got %b want %b", obs, 4'b0000);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            obs = ctl();
            n_cmp++;
            if (obs !== 4'b1110) begin
                n_err++; $display("FAIL rmd_drain%0d: got %b want %b", i, obs, 4'b1110);
            end
        end
        tick();
        obs = ctl();
        n_cmp++;
        if (obs !== 4'b0001) begin
            n_err++; $display("FAIL rmd_fire: got %b want %b", obs, 4'b0001);
        end
        idle();
        tick();
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        idle();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            hif.memtoregE = 1'b1; hif.regwriteE = 1'b1; hif.writeregE = 5'd10; hif.rsD = 5'd10;
            tick();
            idle();
            tick();
        end
        n_cmp++;
        if (stall_cycles !== 32'd5) begin
            n_err++; $display("FAIL perf_lw: got %0d want 5", stall_cycles);
        end
        hif.syscallD = 1'b1;
        tick();
        tick();
        tick();
        tick();
        idle();  // FIRE cycle
        tick();
        tick();
        n_cmp++;
        if (stall_cycles !== 32'd8) begin
            n_err++; $display("FAIL perf_total: got %0d want 8", stall_cycles);
        end
    endtask
`endif

    // Test sequence and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_branch();
        test_zero_reg();
        test_syscall();
        test_back_to_back();
        test_syscall_hz();
        test_reset_mid_drain();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
